imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the word-address width (4096 words).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the instruction word width.
REQ-003 SHALL have parameter LOAD_BURST_MAX, default 8, meaning the maximum consecutive load grants while a fetch is pending (fairness build only).
REQ-004 SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- fetch_req  in  1  CPU fetch request.
- fetch_addr  in  ADDR_W  fetch word address.
- fetch_gnt  out  1  fetch accepted this cycle.
- fetch_rvalid  out  1  fetch data valid.
- fetch_rdata  out  DATA_W  fetch data.
- load_req  in  1  host load-port request.
- load_we  in  1  1 = write, 0 = readback.
- load_addr  in  ADDR_W  load word address.
- load_wdata  in  DATA_W  load write data.
- load_gnt  out  1  load accepted this cycle.
- load_rvalid  out  1  readback data valid.
- load_rdata  out  DATA_W  readback data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a mem_en read.
- cpu_hold  out  1  freezes the CPU program counter.

Function
REQ-005 SHALL compute grants combinationally each cycle; at most one of fetch_gnt and load_gnt SHALL be high.
REQ-006 SHALL, in the base build, give load strict priority: load_gnt = load_req; fetch_gnt = fetch_req & ~load_req.
REQ-007 SHALL drive mem_en = fetch_gnt | load_gnt, with mem_addr and mem_wdata from the granted port, and mem_we = load_gnt & load_we.
REQ-008 SHALL register the read owner (NONE, FETCH or LOAD) at each edge; a granted read SHALL return exactly one cycle later on the owner's rvalid, with rdata = mem_rdata.
REQ-009 SHALL never assert load_rvalid for a load write.
REQ-010 SHALL drive rdata outputs with mem_rdata at all times; rdata is meaningful only while rvalid is high.
REQ-011 SHALL implement a load-session FSM with states IDLE, LOADING and DRAIN:
- IDLE -> LOADING on load_req.
- LOADING -> DRAIN on the first cycle with load_req low.
- DRAIN -> IDLE after 1 cycle, or back to LOADING if load_req reasserts.
REQ-012 SHALL assert cpu_hold = load_req | (state != IDLE), so the CPU PC does not advance past ungranted fetches.
REQ-013 SHALL accept back-to-back grants every cycle with no bubbles.
REQ-014 SHALL keep owner NONE when no grant occurs, so a stale rvalid never fires.

Reset
REQ-015 SHALL, on reset assertion and independent of clk, force: state IDLE, owner NONE, burst counter 0, fetch_rvalid = load_rvalid = 0.
REQ-016 SHALL hold cpu_hold at 0 during reset unless load_req is high; an in-flight read SHALL be discarded when reset is asserted mid-operation.

Configuration
REQ-017 SHALL use macro IMEM_ARB_FAIR_EN; when defined:
- A counter (width clog2(LOAD_BURST_MAX+1)) increments on each load grant made while fetch_req is high.
- When the counter equals LOAD_BURST_MAX and fetch_req is high, the fetch SHALL win for one cycle and the counter SHALL clear.
- The counter SHALL also clear on any cycle with fetch_req low.
- cpu_hold SHALL be deasserted in the forced-fetch cycle.
REQ-018 SHALL, when IMEM_ARB_FAIR_EN is undefined, contain no counter logic and follow REQ-006 exactly.

Structure
REQ-019 SHALL take the owner enum (OWN_NONE, OWN_FETCH, OWN_LOAD) and the session-state enum from shared package imem_pkg, with ADDR_W/DATA_W defaults as package constants.
REQ-020 SHALL be a single module with no sub-modules; the memory array is external.

Verification
REQ-021 Fetch only: fetch_req held, addr 0,1,2 on consecutive cycles -> fetch_gnt on 3 cycles; fetch_rvalid with mem[0..2] on the following 3 cycles; cpu_hold = 0.
REQ-022 Collision: fetch_req and load write (addr 0x010, data 0xDEADBEEF) in the same cycle -> load_gnt = 1, fetch_gnt = 0, mem_we = 1, cpu_hold = 1; subsequent readback of 0x010 -> load_rvalid with 0xDEADBEEF one cycle later.
REQ-023 Session: load_req high for 4 cycles then low -> state LOADING for 4 cycles, DRAIN for 1, then IDLE; cpu_hold high for 5 cycles.
REQ-024 Fairness (IMEM_ARB_FAIR_EN, LOAD_BURST_MAX = 8): continuous load_req and fetch_req -> 8 load grants, 1 fetch grant, repeating; without the macro -> 0 fetch grants.
REQ-025 Reset mid-read: assert reset in the cycle after a granted fetch read -> fetch_rvalid = 0 and state IDLE immediately; first grant after release behaves per REQ-021.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and enums for the instruction-memory arbiter.
// Contents: default address/data widths, read-owner enum, load-session state enum.
package imem_pkg;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} owner_e;
    typedef enum logic [1:0] {S_IDLE, S_LOADING, S_DRAIN} state_e;
endpackage

// File: rtl/imem_arbiter.sv
// imem_arbiter: arbitrates one external instruction memory between CPU fetch and a host load port.
// Ports: clk, reset (async, active-high); fetch_* CPU fetch port; load_* host load port;
// mem_* external single-port memory (read data one cycle after mem_en); cpu_hold freezes the CPU PC.
// Optional macro IMEM_ARB_FAIR_EN: after LOAD_BURST_MAX load grants against a pending fetch,
// the fetch wins one cycle so the CPU cannot be starved by a continuous load stream.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int LOAD_BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              load_req,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_wdata,
    output logic              load_gnt,
    output logic              load_rvalid,
    output logic [DATA_W-1:0] load_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_hold
);
    owner_e owner_q, owner_d;
    state_e state_q, state_d;
`ifdef IMEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(LOAD_BURST_MAX + 1);
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             force_fetch;
`endif

    always_comb begin
`ifdef IMEM_ARB_FAIR_EN
        // The burst counter only advances while a fetch is waiting, so it measures starvation.
        force_fetch = fetch_req && (burst_q == CNT_W'(LOAD_BURST_MAX));
        load_gnt    = load_req & ~force_fetch;
        fetch_gnt   = fetch_req & ~load_gnt;
        burst_d     = (!fetch_req || force_fetch) ? '0 : load_gnt ? burst_q + 1'b1 : burst_q;
        cpu_hold    = (load_req | (state_q != S_IDLE)) & ~force_fetch;
`else
        load_gnt    = load_req;
        fetch_gnt   = fetch_req & ~load_req;
        cpu_hold    = load_req | (state_q != S_IDLE);
`endif
        mem_en      = fetch_gnt | load_gnt;
        mem_we      = load_gnt & load_we;
        mem_addr    = load_gnt ? load_addr : fetch_addr;
        mem_wdata   = load_gnt ? load_wdata : '0;
        // Writes never claim the read path, so no rvalid is produced for them.
        owner_d     = (load_gnt & ~load_we) ? OWN_LOAD : fetch_gnt ? OWN_FETCH : OWN_NONE;
        state_d     = (state_q == S_IDLE)    ? (load_req ? S_LOADING : S_IDLE) :
                      (state_q == S_LOADING) ? (load_req ? S_LOADING : S_DRAIN) :
                                               (load_req ? S_LOADING : S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            state_q <= S_IDLE;
`ifdef IMEM_ARB_FAIR_EN
            burst_q <= '0;
`endif
        end else begin
            owner_q <= owner_d;
            state_q <= state_d;
`ifdef IMEM_ARB_FAIR_EN
            burst_q <= burst_d;
`endif
        end
    end

    assign fetch_rvalid = (owner_q == OWN_FETCH);
    assign load_rvalid  = (owner_q == OWN_LOAD);
    assign fetch_rdata  = mem_rdata;
    assign load_rdata   = mem_rdata;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scoreboard bench for imem_arbiter with an external memory model.
module tb_imem_arbiter;
    import imem_pkg::*;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk, reset;
    logic          fetch_req, load_req, load_we;
    logic [AW-1:0] fetch_addr, load_addr, mem_addr;
    logic [DW-1:0] load_wdata, fetch_rdata, load_rdata, mem_wdata, mem_rdata;
    logic          fetch_gnt, fetch_rvalid, load_gnt, load_rvalid, mem_en, mem_we, cpu_hold;

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOAD_BURST_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .load_req(load_req), .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_gnt(load_gnt), .load_rvalid(load_rvalid), .load_rdata(load_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_hold(cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] lq[$];
    int n_assert = 0;
    int n_fail = 0;
    int n_loading = 0;
    int n_drain = 0;
    int n_busy_hold = 0;

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk)
        if (!reset) begin
            if (fetch_rvalid) begin
                if (fq.size() == 0) chk("fetch_rvalid_unexpected", 1, 0);
                else chk("fetch_rdata", fetch_rdata, fq.pop_front());
            end
            if (load_rvalid) begin
                if (lq.size() == 0) chk("load_rvalid_unexpected", 1, 0);
                else chk("load_rdata", load_rdata, lq.pop_front());
            end
        end

    task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic lr, input logic lw,
                         input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input logic efg, input logic elg, input logic ehold);
        @(posedge clk);
        #1;
        fetch_req = fr; fetch_addr = fa; load_req = lr; load_we = lw; load_addr = la; load_wdata = ld;
        #2;
        chk("fetch_gnt", fetch_gnt, efg);
        chk("load_gnt", load_gnt, elg);
        chk("mem_en", mem_en, efg | elg);
        chk("mem_we", mem_we, elg & lw);
        chk("cpu_hold", cpu_hold, ehold);
        if (elg) chk("mem_addr_load", mem_addr, la);
        else if (efg) chk("mem_addr_fetch", mem_addr, fa);
        if (elg & lw) chk("mem_wdata", mem_wdata, ld);
        if (dut.state_q == S_LOADING) n_loading++;
        if (dut.state_q == S_DRAIN) n_drain++;
        if (dut.state_q != S_IDLE && cpu_hold) n_busy_hold++;
        if (efg) fq.push_back(ref_mem[fa]);
        if (elg && !lw) lq.push_back(ref_mem[la]);
        if (elg && lw) ref_mem[la] = ld;
    endtask

    task automatic idle(input logic ehold);
        drive(0, '0, 0, 0, '0, '0, 0, 0, ehold);
    endtask

    initial begin
        int fg_cnt;
        logic forced;
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
            ref_mem[i] = 32'h1000_0000 + i * 32'h0001_0203;
        end
        reset = 1'b1;
        fetch_req = 0; fetch_addr = '0; load_req = 0; load_we = 0; load_addr = '0; load_wdata = '0;
        #1;
        chk("rst_fetch_rvalid", fetch_rvalid, 0);
        chk("rst_load_rvalid", load_rvalid, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_state", dut.state_q, S_IDLE);
        load_req = 1;
        #1;
        chk("rst_cpu_hold_load", cpu_hold, 1);
        load_req = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // fetch only, back to back
        for (int a = 0; a < 3; a++) drive(1, AW'(a), 0, 0, '0, '0, 1, 0, 0);
        idle(0); idle(0); idle(0);
        chk("fetch_only_drained", fq.size(), 0);

        // collision: load write beats fetch, then readback
        drive(1, 12'h005, 1, 1, 12'h010, 32'hDEAD_BEEF, 0, 1, 1);
        drive(0, '0, 1, 0, 12'h010, '0, 0, 1, 1);
        idle(1); idle(1); idle(0);
        chk("collision_drained", lq.size(), 0);
        chk("collision_ref", ref_mem[12'h010], 32'hDEAD_BEEF);

        // load session: 4 cycles of load_req then release
        n_loading = 0; n_drain = 0; n_busy_hold = 0;
        for (int a = 0; a < 4; a++) drive(0, '0, 1, 0, AW'(20 + a), '0, 0, 1, 1);
        idle(1); idle(1); idle(0);
        chk("session_loading", n_loading, 4);
        chk("session_drain", n_drain, 1);
        chk("session_hold", n_busy_hold, 5);
        chk("session_drained", lq.size(), 0);

        // continuous contention
        fg_cnt = 0;
        for (int k = 0; k < 18; k++) begin
`ifdef IMEM_ARB_FAIR_EN
            forced = (k % 9) == 8;
`else
            forced = 1'b0;
`endif
            drive(1, AW'(40 + k), 1, 0, AW'(60 + k), '0, forced, !forced, !forced);
            if (fetch_gnt) fg_cnt++;
        end
        idle(1); idle(1); idle(0);
`ifdef IMEM_ARB_FAIR_EN
        chk("contention_fetch_grants", fg_cnt, 2);
`else
        chk("contention_fetch_grants", fg_cnt, 0);
`endif
        chk("contention_drained", fq.size() + lq.size(), 0);

        // reset in the cycle after a granted fetch read
        drive(1, 12'h007, 0, 0, '0, '0, 1, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        fetch_req = 0;
        fq.delete();
        #1;
        chk("midrst_fetch_rvalid", fetch_rvalid, 0);
        chk("midrst_state", dut.state_q, S_IDLE);
        chk("midrst_cpu_hold", cpu_hold, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 3; a++) drive(1, AW'(a), 0, 0, '0, '0, 1, 0, 0);
        idle(0); idle(0); idle(0);
        chk("post_rst_drained", fq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
